traffic_phase_sched: RTL and testbench

Parametrised per-junction phase scheduler, the next generation of the traffic-signal controller. It serves N_APP approaches instead of a fixed four. Each phase it picks one approach using latched vehicle density, priority, wait-age and emergency requests, then sizes that approach's green time from its density. It sits between the image-derived density path (14-bit counts) and the lamp drivers, one instance per junction.

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/traffic_score_arbiter.sv | 55 +++++
 rtl/traffic_phase_sched.sv | 147 ++++++++++++++
 tb/tb_traffic_phase_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp encodings, scheduler states and score sizing for the phase scheduler.
// Pure declarations; no timing or flow control of its own.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;

  typedef enum logic [1:0] {
    ST_ALL_RED,
    ST_SELECT,
    ST_GREEN,
    ST_YELLOW
  } state_t;

  // Widest shifted term, plus guard bits so the three-term sum cannot wrap.
  function automatic int score_width(input int cnt_w, input int pri_w, input int prio_shift,
                                     input int age_w, input int age_shift);
    int w;
    w = cnt_w;
    if (pri_w + prio_shift > w) w = pri_w + prio_shift;
    if (age_w + age_shift > w) w = age_w + age_shift;
    return w + $clog2(3);
  endfunction

endpackage

// File: rtl/traffic_score_arbiter.sv
// Combinational approach picker: emergency override, else highest nonzero score, lowest index on ties.
// Zero latency; no flow control.
module traffic_score_arbiter
  import traffic_pkg::*;
#(
  parameter int N_APP      = 4,
  parameter int CNT_W      = 14,
  parameter int PRI_W      = 4,
  parameter int AGE_W      = 4,
  parameter int PRIO_SHIFT = 4,
  parameter int AGE_SHIFT  = 6,
  localparam int IDX_W     = $clog2(N_APP)
) (
  input  logic [N_APP*CNT_W-1:0] dens,
  input  logic [N_APP*PRI_W-1:0] prio,
  input  logic [N_APP*AGE_W-1:0] age,
  input  logic [N_APP-1:0]       emerg,
  output logic [IDX_W-1:0]       win_idx,
  output logic                   win_vld,
  output logic                   win_emerg
);

  localparam int SCORE_W = score_width(CNT_W, PRI_W, PRIO_SHIFT, AGE_W, AGE_SHIFT);

  logic [SCORE_W-1:0] best;
  logic [SCORE_W-1:0] score;

  always_comb begin
    win_idx   = '0;
    win_vld   = 1'b0;
    win_emerg = 1'b0;
    best      = '0;
    score     = '0;
    if (|emerg) begin
      win_vld   = 1'b1;
      win_emerg = 1'b1;
      for (int i = N_APP - 1; i >= 0; i--) begin
        if (emerg[i]) win_idx = IDX_W'(i);
      end
    end else begin
      // Strict compare keeps the lowest index on ties and rejects all-zero scores.
      for (int i = 0; i < N_APP; i++) begin
        score = SCORE_W'(dens[i*CNT_W +: CNT_W])
              + (SCORE_W'(prio[i*PRI_W +: PRI_W]) << PRIO_SHIFT)
              + (SCORE_W'(age[i*AGE_W +: AGE_W]) << AGE_SHIFT);
        if (score > best) begin
          best    = score;
          win_idx = IDX_W'(i);
          win_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/traffic_phase_sched.sv
// Per-junction phase scheduler: all-red, select, density-sized green, yellow; emergency hold/preempt.
// Registered outputs; green appears T_ALLRED+1 cycles after all-red entry; no backpressure.
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int N_APP       = 4,
  parameter int CNT_W       = 14,
  parameter int PRI_W       = 4,
  parameter int AGE_W       = 4,
  parameter int PRIO_SHIFT  = 4,
  parameter int AGE_SHIFT   = 6,
  parameter int DENS_SHIFT  = 2,
  parameter int T_MIN_GREEN = 4,
  parameter int T_MAX_GREEN = 20,
  parameter int T_YEL       = 3,
  parameter int T_ALLRED    = 2,
  localparam int IDX_W      = $clog2(N_APP)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_APP*CNT_W-1:0] density,
  input  logic                   density_vld,
  input  logic [N_APP*PRI_W-1:0] prio,
  input  logic [N_APP-1:0]       emerg,
  output logic [N_APP*2-1:0]     light,
  output logic [IDX_W-1:0]       active_idx,
  output logic                   emerg_active,
  output logic                   phase_done
);

  localparam int TMR_W = $clog2(T_MAX_GREEN + T_YEL + T_ALLRED + 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_MIN    = TMR_W'(T_MIN_GREEN);
  localparam logic [TMR_W-1:0] TMR_MAX    = TMR_W'(T_MAX_GREEN);
  localparam logic [TMR_W-1:0] TMR_YEL    = TMR_W'(T_YEL);
  localparam logic [TMR_W-1:0] TMR_ALLRED = TMR_W'(T_ALLRED);

  state_t                 state;
  logic [TMR_W-1:0]       timer;
  logic [N_APP*CNT_W-1:0] dens_q;
  logic [N_APP*AGE_W-1:0] age_q;

  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic             win_emerg;
  logic [CNT_W:0]   green_ext;
  logic [TMR_W-1:0] green_time;
  logic [N_APP-1:0] emerg_other;
  logic             preempt;
  logic             hold;

  traffic_score_arbiter #(
    .N_APP      (N_APP),
    .CNT_W      (CNT_W),
    .PRI_W      (PRI_W),
    .AGE_W      (AGE_W),
    .PRIO_SHIFT (PRIO_SHIFT),
    .AGE_SHIFT  (AGE_SHIFT)
  ) u_arb (
    .dens      (dens_q),
    .prio      (prio),
    .age       (age_q),
    .emerg     (emerg),
    .win_idx   (win_idx),
    .win_vld   (win_vld),
    .win_emerg (win_emerg)
  );

  always_comb begin
    green_ext  = (CNT_W+1)'(T_MIN_GREEN)
               + (CNT_W+1)'(dens_q[win_idx*CNT_W +: CNT_W] >> DENS_SHIFT);
    green_time = (green_ext > (CNT_W+1)'(T_MAX_GREEN)) ? TMR_MAX : TMR_W'(green_ext);
    emerg_other             = emerg;
    emerg_other[active_idx] = 1'b0;
    preempt = |emerg_other;
    hold    = emerg_active && emerg[active_idx];
  end

  function automatic logic [N_APP*2-1:0] lamp_vec(input logic [IDX_W-1:0] idx,
                                                  input logic [1:0] code);
    lamp_vec = '0;
    lamp_vec[idx*2 +: 2] = code;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_ALL_RED;
      timer        <= TMR_ALLRED;
      dens_q       <= '0;
      age_q        <= '0;
      light        <= '0;
      active_idx   <= '0;
      emerg_active <= 1'b0;
      phase_done   <= 1'b0;
    end else begin
      phase_done <= 1'b0;
      if (density_vld) dens_q <= density;
      case (state)
        ST_ALL_RED: begin
          if (timer == TMR_ONE) state <= ST_SELECT;
          else                  timer <= timer - TMR_ONE;
        end
        ST_SELECT: begin
          if (win_vld) begin
            state        <= ST_GREEN;
            timer        <= win_emerg ? TMR_MIN : green_time;
            active_idx   <= win_idx;
            emerg_active <= win_emerg;
            light        <= lamp_vec(win_idx, LIGHT_GREEN);
          end else begin
            state <= ST_ALL_RED;
            timer <= TMR_ALLRED;
          end
        end
        ST_GREEN: begin
          // An emergency grant parks the timer at 1 until its request drops.
          if (preempt || (timer == TMR_ONE && !hold)) begin
            state      <= ST_YELLOW;
            timer      <= TMR_YEL;
            light      <= lamp_vec(active_idx, LIGHT_YELLOW);
            phase_done <= (T_YEL == 1);
          end else if (timer != TMR_ONE) begin
            timer <= timer - TMR_ONE;
          end
        end
        ST_YELLOW: begin
          if (timer == TMR_ONE) begin
            state        <= ST_ALL_RED;
            timer        <= TMR_ALLRED;
            light        <= '0;
            emerg_active <= 1'b0;
            for (int i = 0; i < N_APP; i++) begin
              if (IDX_W'(i) == active_idx)
                age_q[i*AGE_W +: AGE_W] <= '0;
              else if (dens_q[i*CNT_W +: CNT_W] != '0 && age_q[i*AGE_W +: AGE_W] != '1)
                age_q[i*AGE_W +: AGE_W] <= age_q[i*AGE_W +: AGE_W] + 1'b1;
            end
          end else begin
            timer      <= timer - TMR_ONE;
            phase_done <= (timer == TMR_W'(2));
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Scoreboard bench for traffic_phase_sched: expected phases queued at stimulus time,
// matched when the observed green ends.
module tb_traffic_phase_sched;

  localparam int N_APP = 4, CNT_W = 14, PRI_W = 4, AGE_W = 4;
  localparam int T_MIN = 4, T_MAX = 20, T_YEL = 3, T_ALLRED = 2, DENS_SHIFT = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N_APP*CNT_W-1:0] density = '0;
  logic                   density_vld = 1'b0;
  logic [N_APP*PRI_W-1:0] prio = '0;
  logic [N_APP-1:0]       emerg = '0;
  logic [N_APP*2-1:0]     light;
  logic [1:0]             active_idx;
  logic                   emerg_active;
  logic                   phase_done;

  traffic_phase_sched #(
    .N_APP(N_APP), .CNT_W(CNT_W), .PRI_W(PRI_W), .AGE_W(AGE_W),
    .PRIO_SHIFT(4), .AGE_SHIFT(6), .DENS_SHIFT(DENS_SHIFT),
    .T_MIN_GREEN(T_MIN), .T_MAX_GREEN(T_MAX), .T_YEL(T_YEL), .T_ALLRED(T_ALLRED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .density(density), .density_vld(density_vld),
    .prio(prio), .emerg(emerg), .light(light), .active_idx(active_idx),
    .emerg_active(emerg_active), .phase_done(phase_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int len;
    int em;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   n_pushed = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  function automatic int exp_green(input int d);
    int g;
    g = T_MIN + (d >> DENS_SHIFT);
    if (g > T_MAX) g = T_MAX;
    return g;
  endfunction

  function automatic logic [1:0] lamp(input int i);
    return light[i*2 +: 2];
  endfunction

  task automatic push(input int idx, input int len, input int em);
    exp_t e;
    e.idx = idx; e.len = len; e.em = em;
    sbq.push_back(e);
    n_pushed++;
  endtask

  // Monitor: measures each phase from the lamps and pops the scoreboard at green->yellow.
  int gcnt = 0, ycnt = 0, rcnt = 0, g_idx = 0, g_em = 0;
  int after_y = 0, viol = 0, pd_total = 0, pd_stray = 0;

  always @(negedge clk) begin
    int nonred, gi, yi;
    exp_t e;
    if (!rst_n) begin
      gcnt = 0; ycnt = 0; rcnt = 0; after_y = 0;
    end else begin
      nonred = 0; gi = -1; yi = -1;
      for (int i = 0; i < N_APP; i++) begin
        if (lamp(i) != 2'b00) nonred++;
        if (lamp(i) == 2'b01) gi = i;
        if (lamp(i) == 2'b10) yi = i;
      end
      if (nonred > 1) viol++;
      if (gi >= 0) begin
        if (gcnt == 0 && after_y != 0) chk("allred_gap", rcnt, T_ALLRED + 1);
        if (gcnt == 0) begin
          g_idx = gi;
          g_em  = int'(emerg_active);
        end
        gcnt++;
        after_y = 0;
      end else if (yi >= 0) begin
        if (gcnt > 0) begin
          if (sbq.size() == 0) begin
            chk("unexp_phase", gcnt, 0);
          end else begin
            e = sbq.pop_front();
            chk("win_idx", g_idx, e.idx);
            chk("green_len", gcnt, e.len);
            chk("emerg_act", g_em, e.em);
            chk("active_idx", int'(active_idx), e.idx);
          end
          gcnt = 0;
          ycnt = 0;
        end
        ycnt++;
        if (phase_done) begin
          pd_total++;
          chk("pd_pos", ycnt, T_YEL);
        end
      end else begin
        if (ycnt > 0) begin
          chk("yel_len", ycnt, T_YEL);
          ycnt = 0;
          after_y = 1;
          rcnt = 0;
        end
        rcnt++;
        if (phase_done) pd_stray++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0; density_vld = 1'b0; emerg = '0; prio = '0; density = '0;
    repeat (3) @(negedge clk);
  endtask

  // Release reset and latch densities in the first all-red cycle.
  task automatic release_with(input int d0, input int d1, input int d2, input int d3);
    #2;
    rst_n = 1'b1;
    density = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    density_vld = 1'b1;
    @(negedge clk);
    density_vld = 1'b0;
  endtask

  task automatic wait_lamp(input string tag, input int i, input logic [1:0] code);
    int n;
    n = 0;
    while (lamp(i) != code && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (lamp(i) != code) chk(tag, int'(lamp(i)), int'(code));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) chk(tag, sbq.size(), 0);
    n = 0;
    while (light != '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (light != '0) chk({tag, "_red"}, int'(light), 0);
  endtask

  initial begin
    int cyc, nz, pd;

    // Reset state while rst_n is held low.
    repeat (3) @(negedge clk);
    chk("rst_light", int'(light), 0);
    chk("rst_active_idx", int'(active_idx), 0);
    chk("rst_emerg_active", int'(emerg_active), 0);
    chk("rst_phase_done", int'(phase_done), 0);

    // density {0,40,8,0}: 1 (14), then 2 by age (8+64 > 40, 6), then 1 again (40+64).
    push(1, exp_green(40), 0);
    push(2, exp_green(8), 0);
    push(1, exp_green(40), 0);
    release_with(0, 40, 8, 0);
    cyc = 1;
    while (light == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("first_green_lat", cyc, T_ALLRED + 1);
    wait_done("s1");

    // Large density clamps to the maximum green.
    do_reset();
    push(0, T_MAX, 0);
    release_with(200, 0, 0, 0);
    wait_done("s2");

    // Priority outweighs density, then age brings the denser approach back.
    do_reset();
    push(2, T_MIN, 0);
    push(1, exp_green(40), 0);
    prio = {4'd0, 4'd3, 4'd0, 4'd0};
    release_with(0, 40, 0, 0);
    wait_done("s6");

    // Preemption in green cycle 2, then emergency hold beyond minimum green.
    do_reset();
    push(1, 2, 0);
    push(3, 10, 1);
    release_with(0, 40, 0, 0);
    wait_lamp("s3_g1", 1, 2'b01);
    @(negedge clk);
    emerg = 4'b1000;
    wait_lamp("s3_g3", 3, 2'b01);
    repeat (9) @(negedge clk);
    chk("emerg_hold_green", int'(lamp(3)), 1);
    chk("emerg_hold_flag", int'(emerg_active), 1);
    emerg = '0;
    @(negedge clk);
    chk("emerg_release_yel", int'(lamp(3)), 2);
    wait_done("s3");

    // Idle: nothing to serve, lamps stay red, no phase_done.
    do_reset();
    release_with(0, 0, 0, 0);
    nz = 0; pd = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (light != '0) nz++;
      if (phase_done) pd++;
    end
    chk("idle_light", nz, 0);
    chk("idle_pd", pd, 0);
    chk("idle_active_idx", int'(active_idx), 0);

    // Reset mid-green of approach 2 (age of 2 nonzero beforehand) clears lamps and ages.
    do_reset();
    push(1, exp_green(40), 0);
    release_with(0, 40, 8, 0);
    wait_lamp("s4_g2", 2, 2'b01);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_light", int'(light), 0);
    chk("midrst_active", int'(active_idx), 0);
    chk("midrst_emerg", int'(emerg_active), 0);
    repeat (2) @(negedge clk);
    push(1, exp_green(40), 0);
    release_with(0, 40, 8, 0);
    wait_done("s4");

    chk("onehot_viol", viol, 0);
    chk("pd_total", pd_total, n_pushed);
    chk("pd_stray", pd_stray, 0);
    chk("q_left", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
